// File: rtl/sll_pkg.sv
// Shared definitions for the singly linked list core: op codes, FSM states,
// per-cycle action codes and the null-pointer helper.
package sll_pkg;

  typedef enum logic [2:0] {
    OP_READ     = 3'd0,
    OP_INS_ADDR = 3'd1,
    OP_DEL_VAL  = 3'd2,
    OP_DEL_ADDR = 3'd3,
    OP_INS_IDX  = 3'd5,
    OP_DEL_IDX  = 3'd7
  } sll_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WALK = 2'd2,
    ST_DONE = 2'd3
  } sll_state_e;

  // What the datapath does on the current clock edge.
  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_FAULT  = 3'd1,
    ACT_READ   = 3'd2,
    ACT_APPEND = 3'd3,
    ACT_INSERT = 3'd4,
    ACT_UNLINK = 3'd5,
    ACT_WALK   = 3'd6,
    ACT_STEP   = 3'd7
  } sll_act_e;

  // All-ones pointer of the given width marks "no node".
  function automatic int unsigned null_addr(input int unsigned w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sll_free_slot_finder.sv
// Lowest-index free node slot: priority encoder over the valid bits,
// with a flag when every slot is occupied.
module sll_free_slot_finder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] valid,
  output logic [W-1:0] slot,
  output logic         none_free
);

  // Scanning downward lets the lowest free index win.
  always_comb begin
    slot      = '0;
    none_free = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        slot      = W'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/singly_linked_list_core.sv
// Singly linked list held in register node storage, driven one operation at a
// time; index/value operations walk the list from head one node per cycle.
module singly_linked_list_core
  import sll_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_NODE   = 8,
  localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [2:0]            op,
  input  logic                  op_start,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  op_done,
  output logic [ADDR_WIDTH-1:0] next_node_addr,
  output logic [ADDR_WIDTH-1:0] length,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] head,
  output logic [ADDR_WIDTH-1:0] tail,
  output logic                  empty,
  output logic                  fault,
  output logic [1:0]            fsm_state
);

  localparam int SLOT_W = (MAX_NODE > 1) ? $clog2(MAX_NODE) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = ADDR_WIDTH'(null_addr(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN   = ADDR_WIDTH'(MAX_NODE);

  // Node storage
  logic [DATA_WIDTH-1:0] data_q [MAX_NODE];
  logic [ADDR_WIDTH-1:0] nxt_q  [MAX_NODE];
  logic [MAX_NODE-1:0]   valid_q;

  // Control and list status
  sll_state_e            state_q;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [ADDR_WIDTH-1:0] cur_q;
  logic [ADDR_WIDTH-1:0] prev_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] head_q;
  logic [ADDR_WIDTH-1:0] tail_q;
  logic [ADDR_WIDTH-1:0] length_q;
  logic [ADDR_WIDTH-1:0] next_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  op_done_q;
  logic                  fault_q;

  logic [SLOT_W-1:0]     free_slot;
  logic                  none_free;
  logic [ADDR_WIDTH-1:0] free_addr;
  logic [SLOT_W-1:0]     cur_s;
  logic [SLOT_W-1:0]     prev_s;
  logic [SLOT_W-1:0]     addr_s;
  logic [SLOT_W-1:0]     tail_s;

  sll_act_e act;
  logic     addr_ok;
  logic     hit;
  logic     is_insert;
  logic     finish;

  sll_free_slot_finder #(
    .N (MAX_NODE),
    .W (SLOT_W)
  ) u_free_slot (
    .valid     (valid_q),
    .slot      (free_slot),
    .none_free (none_free)
  );

  assign free_addr = ADDR_WIDTH'(free_slot);
  assign cur_s     = cur_q[SLOT_W-1:0];
  assign prev_s    = prev_q[SLOT_W-1:0];
  assign addr_s    = addr_q[SLOT_W-1:0];
  assign tail_s    = tail_q[SLOT_W-1:0];
  assign addr_ok   = (addr_q < MAX_LEN) && valid_q[addr_s];

  // Decide this cycle's action from the latched request and the walk cursor.
  always_comb begin
    act       = ACT_NONE;
    is_insert = (op_q == OP_INS_ADDR) || (op_q == OP_INS_IDX);
    hit       = 1'b0;
    case (op_q)
      OP_INS_ADDR, OP_DEL_ADDR: hit = (cur_q == addr_q);
      OP_INS_IDX,  OP_DEL_IDX:  hit = (cnt_q == addr_q);
      OP_DEL_VAL:               hit = (data_q[cur_s] == din_q);
      default:                  hit = 1'b1;
    endcase

    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_READ: act = addr_ok ? ACT_READ : ACT_FAULT;
        OP_INS_ADDR: begin
          if (none_free || ((addr_q != ADDR_NULL) && !addr_ok)) act = ACT_FAULT;
          else if (addr_q == ADDR_NULL)                          act = ACT_APPEND;
          else                                                   act = ACT_WALK;
        end
        OP_INS_IDX: begin
          if (none_free)               act = ACT_FAULT;
          else if (addr_q >= length_q) act = ACT_APPEND;
          else                         act = ACT_WALK;
        end
        OP_DEL_VAL:  act = (length_q == '0) ? ACT_FAULT : ACT_WALK;
        OP_DEL_ADDR: act = addr_ok ? ACT_WALK : ACT_FAULT;
        OP_DEL_IDX:  act = (addr_q >= length_q) ? ACT_FAULT : ACT_WALK;
        default:     act = ACT_FAULT;
      endcase
    end else if (state_q == ST_WALK) begin
      // Running off the tail only happens for a value that is not in the list.
      if (cur_q == ADDR_NULL) act = ACT_FAULT;
      else if (hit)           act = is_insert ? ACT_INSERT : ACT_UNLINK;
      else                    act = ACT_STEP;
    end

    finish = (act == ACT_FAULT) || (act == ACT_READ) || (act == ACT_APPEND) ||
             (act == ACT_INSERT) || (act == ACT_UNLINK);
  end

  // Handshake: op_start is a level request taken only in IDLE, at which point
  // op/addr_in/data_in are latched; op_done pulses for the one DONE cycle, when
  // fault, read data and list status are already updated. No re-arm in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      head_q     <= ADDR_NULL;
      tail_q     <= ADDR_NULL;
      length_q   <= '0;
      next_q     <= ADDR_NULL;
      data_out_q <= '0;
      op_done_q  <= 1'b0;
      fault_q    <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      cur_q      <= ADDR_NULL;
      prev_q     <= ADDR_NULL;
      cnt_q      <= '0;
    end else begin
      op_done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (op_start) begin
            op_q    <= op;
            addr_q  <= addr_in;
            din_q   <= data_in;
            state_q <= ST_EXEC;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: ;
      endcase

      case (act)
        ACT_READ: begin
          data_out_q <= data_q[addr_s];
          next_q     <= nxt_q[addr_s];
        end
        ACT_APPEND: begin
          data_q[free_slot]  <= din_q;
          nxt_q[free_slot]   <= ADDR_NULL;
          valid_q[free_slot] <= 1'b1;
          if (tail_q == ADDR_NULL) head_q <= free_addr;
          else                     nxt_q[tail_s] <= free_addr;
          tail_q   <= free_addr;
          length_q <= length_q + 1'b1;
        end
        ACT_INSERT: begin
          // New node goes in front of cur; tail never moves here.
          data_q[free_slot]  <= din_q;
          nxt_q[free_slot]   <= cur_q;
          valid_q[free_slot] <= 1'b1;
          if (prev_q == ADDR_NULL) head_q <= free_addr;
          else                     nxt_q[prev_s] <= free_addr;
          length_q <= length_q + 1'b1;
        end
        ACT_UNLINK: begin
          if (prev_q == ADDR_NULL) head_q <= nxt_q[cur_s];
          else                     nxt_q[prev_s] <= nxt_q[cur_s];
          if (cur_q == tail_q) tail_q <= prev_q;
          valid_q[cur_s] <= 1'b0;
          length_q       <= length_q - 1'b1;
        end
        ACT_WALK: begin
          cur_q   <= head_q;
          prev_q  <= ADDR_NULL;
          cnt_q   <= '0;
          state_q <= ST_WALK;
        end
        ACT_STEP: begin
          prev_q <= cur_q;
          cur_q  <= nxt_q[cur_s];
          cnt_q  <= cnt_q + 1'b1;
        end
        default: ;
      endcase

      if (finish) begin
        state_q   <= ST_DONE;
        op_done_q <= 1'b1;
        fault_q   <= (act == ACT_FAULT);
      end
    end
  end

  assign data_out       = data_out_q;
  assign op_done        = op_done_q;
  assign next_node_addr = next_q;
  assign length         = length_q;
  assign head           = head_q;
  assign tail           = tail_q;
  assign full           = (length_q == MAX_LEN);
  assign empty          = (length_q == '0);
  assign fault          = fault_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_singly_linked_list_core.sv
// Directed bench for singly_linked_list_core: list contents are tracked in an
// expected queue and checked through status outputs and read walks.
module tb_singly_linked_list_core;
  import sll_pkg::*;

  localparam logic [3:0] NUL = 4'hF;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic [3:0] addr_in;
  logic [2:0] op;
  logic       op_start;
  logic [7:0] data_out;
  logic       op_done;
  logic [3:0] next_node_addr;
  logic [3:0] length;
  logic       full;
  logic [3:0] head;
  logic [3:0] tail;
  logic       empty;
  logic       fault;
  logic [1:0] fsm_state;

  logic [7:0] exp_q[$];
  int         n_vec;
  int         n_err;

  logic [3:0] ins_idx [8] = '{4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd1, 4'd2, NUL};
  logic [7:0] ins_dat [8] = '{8'd3, 8'd0, 8'd5, 8'd6, 8'd7, 8'd3, 8'd4, 8'd3};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  singly_linked_list_core #(
    .DATA_WIDTH (8),
    .MAX_NODE   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .addr_in        (addr_in),
    .op             (op),
    .op_start       (op_start),
    .data_out       (data_out),
    .op_done        (op_done),
    .next_node_addr (next_node_addr),
    .length         (length),
    .full           (full),
    .head           (head),
    .tail           (tail),
    .empty          (empty),
    .fault          (fault),
    .fsm_state      (fsm_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: one request, then wait (bounded) for op_done.
  task automatic run_op(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    op = o; addr_in = a; data_in = d; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    n = 0;
    while (!op_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("op_done", 32'(op_done), 32'd1);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, " length"}, 32'(length), 32'(exp_q.size()));
    check_eq({tag, " empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check_eq({tag, " full"}, 32'(full), 32'(exp_q.size() == 8));
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [3:0] a,
                       input logic [7:0] d, input logic exp_fault);
    run_op(o, a, d);
    check_eq({tag, " fault"}, 32'(fault), 32'(exp_fault));
    check_status(tag);
  endtask

  task automatic walk(input string tag);
    logic [3:0] a;
    a = head;
    for (int i = 0; i < exp_q.size(); i++) begin
      run_op(OP_READ, a, 8'd0);
      check_eq({tag, " data"}, 32'(data_out), 32'(exp_q[i]));
      check_eq({tag, " rd_fault"}, 32'(fault), 32'd0);
      a = next_node_addr;
    end
    check_eq({tag, " last_next"}, 32'(next_node_addr), 32'(NUL));
  endtask

  initial begin
    int k;
    int n;
    n_vec = 0; n_err = 0;
    rst = 1'b1; op_start = 1'b0; op = 3'd0; addr_in = 4'd0; data_in = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst empty", 32'(empty), 32'd1);
    check_eq("rst full", 32'(full), 32'd0);
    check_eq("rst length", 32'(length), 32'd0);
    check_eq("rst head", 32'(head), 32'(NUL));
    check_eq("rst tail", 32'(tail), 32'(NUL));
    check_eq("rst next", 32'(next_node_addr), 32'(NUL));
    check_eq("rst op_done", 32'(op_done), 32'd0);
    check_eq("rst fault", 32'(fault), 32'd0);
    rst = 1'b0;

    // Build [7,3,4,6,0,3,5,3] by index
    for (int i = 0; i < 8; i++) begin
      if (int'(ins_idx[i]) < exp_q.size()) exp_q.insert(int'(ins_idx[i]), ins_dat[i]);
      else exp_q.push_back(ins_dat[i]);
      do_op("ins_idx", OP_INS_IDX, ins_idx[i], ins_dat[i], 1'b0);
    end
    check_eq("full head", 32'(head), 32'd4);
    check_eq("full tail", 32'(tail), 32'd7);
    do_op("ins_full_a", OP_INS_IDX, NUL, 8'd4, 1'b1);
    do_op("ins_full_b", OP_INS_IDX, NUL, 8'd1, 1'b1);
    do_op("ins_full_c", OP_INS_IDX, 4'd0, 8'd3, 1'b1);
    do_op("ins_full_d", OP_INS_ADDR, NUL, 8'd2, 1'b1);
    walk("walk8");

    // Deletions down to [3]
    exp_q.delete(0);
    do_op("del_val7", OP_DEL_VAL, 4'd0, 8'd7, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.delete(0);
      do_op("del_idx0", OP_DEL_IDX, 4'd0, 8'd0, 1'b0);
    end
    walk("walk5");
    do_op("del_val2", OP_DEL_VAL, 4'd0, 8'd2, 1'b1);
    do_op("del_val4", OP_DEL_VAL, 4'd0, 8'd4, 1'b1);
    exp_q.delete(0);
    do_op("del_idx0b", OP_DEL_IDX, 4'd0, 8'd0, 1'b0);
    do_op("del_idx7", OP_DEL_IDX, 4'd7, 8'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      k = exp_q.size() - 1;
      exp_q.delete(k);
      do_op("del_idx_last", OP_DEL_IDX, 4'(k), 8'd0, 1'b0);
    end
    check_eq("two tail", 32'(tail), 32'd0);
    exp_q.delete(0);
    do_op("del_idx0c", OP_DEL_IDX, 4'd0, 8'd0, 1'b0);
    check_eq("one head", 32'(head), 32'd0);
    check_eq("one tail", 32'(tail), 32'd0);
    walk("walk1");

    // Invalid reads/op codes, address-based insert and delete
    do_op("rd_bad", OP_READ, 4'd5, 8'd0, 1'b1);
    do_op("op4", 3'd4, 4'd0, 8'd0, 1'b1);
    do_op("op6", 3'd6, 4'd0, 8'd0, 1'b1);
    exp_q.push_front(8'd9);
    do_op("ins_addr0", OP_INS_ADDR, 4'd0, 8'd9, 1'b0);
    check_eq("ins_addr0 head", 32'(head), 32'd1);
    check_eq("ins_addr0 tail", 32'(tail), 32'd0);
    exp_q.push_back(8'd8);
    do_op("ins_addr_null", OP_INS_ADDR, NUL, 8'd8, 1'b0);
    check_eq("ins_addr_null tail", 32'(tail), 32'd2);
    do_op("ins_addr_bad", OP_INS_ADDR, 4'd6, 8'd1, 1'b1);
    exp_q.delete(1);
    do_op("del_addr0", OP_DEL_ADDR, 4'd0, 8'd0, 1'b0);
    check_eq("del_addr0 head", 32'(head), 32'd1);
    do_op("del_addr0_again", OP_DEL_ADDR, 4'd0, 8'd0, 1'b1);

    // Back-to-back reads with op_start held: 2-cycle latency, then 3-cycle spacing
    @(negedge clk);
    op = OP_READ; addr_in = head; op_start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!op_done && n < 20);
      check_eq("b2b latency", 32'(n), (i == 0) ? 32'd2 : 32'd3);
      check_eq("b2b data", 32'(data_out), 32'(exp_q[i]));
      addr_in = next_node_addr;
      if (i == 1) op_start = 1'b0;
    end
    check_eq("b2b last_next", 32'(next_node_addr), 32'(NUL));

    exp_q.delete(1);
    do_op("del_addr2", OP_DEL_ADDR, 4'd2, 8'd0, 1'b0);
    check_eq("del_addr2 tail", 32'(tail), 32'd1);
    exp_q.delete(0);
    do_op("del_last", OP_DEL_IDX, 4'd0, 8'd0, 1'b0);
    check_eq("empty head", 32'(head), 32'(NUL));
    check_eq("empty tail", 32'(tail), 32'(NUL));
    do_op("del_idx_empty", OP_DEL_IDX, 4'd0, 8'd0, 1'b1);
    do_op("del_val_empty", OP_DEL_VAL, 4'd0, 8'd9, 1'b1);
    exp_q.push_back(8'd5);
    do_op("ins_idx_empty", OP_INS_IDX, 4'd3, 8'd5, 1'b0);
    check_eq("ins_idx_empty head", 32'(head), 32'd0);
    walk("walk_re");

    // Reset on a non-empty list clears it
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check_status("rst2");
    check_eq("rst2 head", 32'(head), 32'(NUL));
    do_op("rst2 rd", OP_READ, 4'd0, 8'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
